// File: rtl/ex_div_ctrl_pkg.sv
// Shared constants for the EX-stage divide sequencer: ALU opcodes, divider handshake
// levels and controller state encoding.
package ex_div_ctrl_pkg;

    localparam logic [7:0] EXE_DIV_OP  = 8'b0001_1010;
    localparam logic [7:0] EXE_DIVU_OP = 8'b0001_1011;

    localparam logic DivResultReady    = 1'b1;
    localparam logic DivResultNotReady = 1'b0;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StBusy  = 2'd1,
        StDrain = 2'd2
    } div_state_e;

    function automatic logic is_div_op(input logic [7:0] op);
        return (op == EXE_DIV_OP) || (op == EXE_DIVU_OP);
    endfunction

endpackage

// File: rtl/ex_div_ctrl.sv
// EX-stage divide sequencer: issues DIV/DIVU to the divider, stalls until done, writes HI/LO.
// Optional macro DIV_FASTZERO_EN: zero divisors complete in IDLE without using the divider.
module ex_div_ctrl
    import ex_div_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  aluop_i,
    input  logic [31:0] reg1_i,
    input  logic [31:0] reg2_i,
    input  logic        flush_i,
    input  logic [63:0] div_result_i,
    input  logic        div_ready_i,
    output logic        div_start_o,
    output logic        div_cancel_o,
    output logic        div_sign_o,
    output logic [31:0] div_opdata1_o,
    output logic [31:0] div_opdata2_o,
    output logic        stallreq_o,
    output logic        whilo_o,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o
);

    div_state_e  state_q;
    logic        start_q;
    logic        sign_q;
    logic [31:0] op1_q;
    logic [31:0] op2_q;

    logic is_div;
    logic fast_zero;
    logic issue;

    assign is_div = is_div_op(aluop_i);

`ifdef DIV_FASTZERO_EN
    assign fast_zero = (reg2_i == 32'd0);
`else
    assign fast_zero = 1'b0;
`endif

    assign issue = (state_q == StIdle) && is_div && !flush_i && !fast_zero;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            start_q <= 1'b0;
            sign_q  <= 1'b0;
            op1_q   <= 32'd0;
            op2_q   <= 32'd0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (issue) begin
                        op1_q   <= reg1_i;
                        op2_q   <= reg2_i;
                        sign_q  <= (aluop_i == EXE_DIV_OP);
                        start_q <= 1'b1;
                        state_q <= StBusy;
                    end
                end
                StBusy: begin
                    // Flush wins over a same-cycle ready so no HI/LO write escapes.
                    if (flush_i) begin
                        start_q <= 1'b0;
                        state_q <= StIdle;
                    end else if (div_ready_i == DivResultReady) begin
                        start_q <= 1'b0;
                        state_q <= StDrain;
                    end
                end
                StDrain: begin
                    state_q <= StIdle;
                end
                default: begin
                    start_q <= 1'b0;
                    state_q <= StIdle;
                end
            endcase
        end
    end

    always_comb begin
        div_start_o   = 1'b0;
        div_cancel_o  = 1'b0;
        div_sign_o    = 1'b0;
        div_opdata1_o = 32'd0;
        div_opdata2_o = 32'd0;
        stallreq_o    = 1'b0;
        whilo_o       = 1'b0;
        hi_o          = 32'd0;
        lo_o          = 32'd0;
        if (!rst) begin
            unique case (state_q)
                StIdle: begin
                    stallreq_o = issue;
                    // Fast zero-divisor path leaves hi_o/lo_o at their zero defaults.
                    whilo_o    = is_div && fast_zero && !flush_i;
                end
                StBusy: begin
                    div_start_o   = start_q;
                    div_sign_o    = sign_q;
                    div_opdata1_o = op1_q;
                    div_opdata2_o = op2_q;
                    if (flush_i) begin
                        div_cancel_o = 1'b1;
                    end else if (div_ready_i == DivResultReady) begin
                        whilo_o = 1'b1;
                        hi_o    = div_result_i[63:32];
                        lo_o    = div_result_i[31:0];
                    end else begin
                        stallreq_o = 1'b1;
                    end
                end
                StDrain: begin
                    stallreq_o = is_div;
                end
                default: begin
                    stallreq_o = 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ex_div_ctrl.sv
// Scoreboard bench for ex_div_ctrl: directed divides, a bench-side divider stand-in, and a
// monitor that pops expected HI/LO on every whilo_o pulse.
module tb_ex_div_ctrl;
    import ex_div_ctrl_pkg::*;

    localparam logic [7:0] NOP = 8'h00;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  aluop_i;
    logic [31:0] reg1_i;
    logic [31:0] reg2_i;
    logic        flush_i;
    logic [63:0] div_result_i;
    logic        div_ready_i;
    logic        div_start_o;
    logic        div_cancel_o;
    logic        div_sign_o;
    logic [31:0] div_opdata1_o;
    logic [31:0] div_opdata2_o;
    logic        stallreq_o;
    logic        whilo_o;
    logic [31:0] hi_o;
    logic [31:0] lo_o;

    int checks = 0;
    int passes = 0;
    logic [63:0] exp_q[$];

    always #5 clk = ~clk;

    ex_div_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .aluop_i      (aluop_i),
        .reg1_i       (reg1_i),
        .reg2_i       (reg2_i),
        .flush_i      (flush_i),
        .div_result_i (div_result_i),
        .div_ready_i  (div_ready_i),
        .div_start_o  (div_start_o),
        .div_cancel_o (div_cancel_o),
        .div_sign_o   (div_sign_o),
        .div_opdata1_o(div_opdata1_o),
        .div_opdata2_o(div_opdata2_o),
        .stallreq_o   (stallreq_o),
        .whilo_o      (whilo_o),
        .hi_o         (hi_o),
        .lo_o         (lo_o)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Monitor: every HI/LO write must match the oldest expected result.
    always @(negedge clk) begin
        if (whilo_o === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                $display("FAIL unexpected_whilo: got hi=0x%0h lo=0x%0h, expected no write",
                         hi_o, lo_o);
            end else begin
                chk("hilo_result", {hi_o, lo_o}, exp_q.pop_front());
            end
        end
    end

    // IDLE cycle: present the divide; stall must rise combinationally.
    task automatic issue(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b);
        @(posedge clk); #1;
        aluop_i = op; reg1_i = a; reg2_i = b;
        @(negedge clk);
        chk("issue_stall", stallreq_o, 1);
        chk("issue_start_low", div_start_o, 0);
    endtask

    // BUSY cycles before ready; inputs are scrambled to prove operands are latched.
    task automatic busy(input int n, input logic [31:0] a, input logic [31:0] b,
                        input logic sign);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            reg1_i = ~a; reg2_i = b ^ 32'h5A5A_0001;
            @(negedge clk);
            chk("busy_start", div_start_o, 1);
            chk("busy_stall", stallreq_o, 1);
            chk("busy_sign", div_sign_o, sign);
            chk("busy_ops", {div_opdata1_o, div_opdata2_o}, {a, b});
        end
    endtask

    // Divider reports done; then one DRAIN cycle presenting next_op.
    task automatic complete(input logic [31:0] rem, input logic [31:0] quo,
                            input logic [7:0] next_op, input logic [31:0] na,
                            input logic [31:0] nb);
        @(posedge clk); #1;
        div_ready_i = DivResultReady; div_result_i = {rem, quo};
        exp_q.push_back({rem, quo});
        @(negedge clk);
        chk("done_stall", stallreq_o, 0);
        @(posedge clk); #1;
        div_ready_i = DivResultNotReady; div_result_i = 64'd0;
        aluop_i = next_op; reg1_i = na; reg2_i = nb;
        @(negedge clk);
        chk("drain_start", div_start_o, 0);
        chk("drain_stall", stallreq_o, is_div_op(next_op));
    endtask

    initial begin
        rst = 1'b1; aluop_i = NOP; reg1_i = 0; reg2_i = 0; flush_i = 0;
        div_result_i = 0; div_ready_i = DivResultNotReady;
        repeat (2) @(posedge clk);
        #1;
        aluop_i = EXE_DIVU_OP; reg2_i = 32'd3;
        @(negedge clk);
        chk("reset_outputs", {div_start_o, div_cancel_o, div_sign_o, stallreq_o, whilo_o,
                              div_opdata1_o, div_opdata2_o, hi_o, lo_o}, 0);
        @(posedge clk); #1;
        rst = 1'b0; aluop_i = NOP;

        // DIVU 100 / 7
        issue(EXE_DIVU_OP, 32'd100, 32'd7);
        busy(36, 32'd100, 32'd7, 1'b0);
        complete(32'd2, 32'hE, NOP, 0, 0);

        // DIV -7 / 2
        issue(EXE_DIV_OP, 32'hFFFF_FFF9, 32'd2);
        busy(36, 32'hFFFF_FFF9, 32'd2, 1'b1);
        complete(32'hFFFF_FFFF, 32'hFFFF_FFFD, NOP, 0, 0);

        // DIV 5 / 0
`ifdef DIV_FASTZERO_EN
        @(posedge clk); #1;
        aluop_i = EXE_DIV_OP; reg1_i = 32'd5; reg2_i = 32'd0;
        exp_q.push_back(64'd0);
        @(negedge clk);
        chk("fz_stall", stallreq_o, 0);
        chk("fz_start", div_start_o, 0);
        @(posedge clk); #1;
        aluop_i = NOP;
        @(negedge clk);
        chk("fz_start_after", div_start_o, 0);
`else
        issue(EXE_DIV_OP, 32'd5, 32'd0);
        busy(4, 32'd5, 32'd0, 1'b1);
        complete(32'd0, 32'd0, NOP, 0, 0);
`endif

        // Flush at cycle 10 of BUSY with a simultaneous ready: cancel, no write.
        issue(EXE_DIVU_OP, 32'd50, 32'd5);
        busy(10, 32'd50, 32'd5, 1'b0);
        @(posedge clk); #1;
        flush_i = 1'b1; div_ready_i = DivResultReady; div_result_i = {32'd0, 32'd10};
        @(negedge clk);
        chk("flush_cancel", div_cancel_o, 1);
        chk("flush_stall", stallreq_o, 0);
        @(posedge clk); #1;
        flush_i = 1'b0; div_ready_i = DivResultNotReady; div_result_i = 0; aluop_i = NOP;
        @(negedge clk);
        chk("flush_cancel_pulse", div_cancel_o, 0);
        chk("flush_start_low", div_start_o, 0);

        // Next DIVU issues normally after the flush.
        issue(EXE_DIVU_OP, 32'd100, 32'd7);
        busy(36, 32'd100, 32'd7, 1'b0);
        complete(32'd2, 32'hE, NOP, 0, 0);

        // Back-to-back DIVU 10/3 then 9/4.
        issue(EXE_DIVU_OP, 32'd10, 32'd3);
        busy(36, 32'd10, 32'd3, 1'b0);
        complete(32'd1, 32'd3, EXE_DIVU_OP, 32'd9, 32'd4);
        issue(EXE_DIVU_OP, 32'd9, 32'd4);
        busy(36, 32'd9, 32'd4, 1'b0);
        complete(32'd1, 32'd2, NOP, 0, 0);

        // Reset at cycle 20 of BUSY, ready raised during reset must not write.
        issue(EXE_DIVU_OP, 32'd77, 32'd8);
        busy(20, 32'd77, 32'd8, 1'b0);
        @(posedge clk); #1;
        rst = 1'b1; div_ready_i = DivResultReady; div_result_i = {32'd5, 32'd9};
        @(negedge clk);
        chk("rst_outputs", {div_start_o, div_cancel_o, div_sign_o, stallreq_o, whilo_o,
                            div_opdata1_o, div_opdata2_o, hi_o, lo_o}, 0);
        @(posedge clk); #1;
        rst = 1'b0; div_ready_i = DivResultNotReady; div_result_i = 0; aluop_i = NOP;
        @(negedge clk);
        chk("post_rst_idle", {div_start_o, stallreq_o, whilo_o, div_opdata1_o}, 0);

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("pending_results", exp_q.size(), 0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1);
    end

endmodule
